// File: rtl/hbridge_pkg.sv
// ----------------------------------------------------------------------------
// hbridge_pkg: shared command codes, state encodings and switch patterns. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hbridge_pkg;

    typedef enum logic [2:0] {
        CMD_PAUSE    = 3'd0,
        CMD_PLUS     = 3'd1,
        CMD_MINUS    = 3'd2,
        CMD_BAL_P    = 3'd3,
        CMD_BAL_N    = 3'd4,
        CMD_START    = 3'd5,
        CMD_SHUTDOWN = 3'd6,
        CMD_DISCH    = 3'd7
    } cmd_t;

    // IDLE and S_IDLE must stay at encoding 0: the record reset relies on it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAUSE = 3'd1,
        START = 3'd2,
        DIS0  = 3'd3,
        DIS1  = 3'd4,
        DIS2  = 3'd5,
        DIS3  = 3'd6,
        ERROR = 3'd7
    } dec_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRECHG = 2'd1,
        S_SETTLE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [3:0] top;
        logic [3:0] bot;
        logic       plus;
        logic       minus;
        logic       pause_p;
        logic       pause_n;
    } drive_t;

    localparam drive_t DRV_OFF     = '0;
    localparam drive_t DRV_PLUS    = '{4'b0001, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam drive_t DRV_MINUS   = '{4'b0010, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam drive_t DRV_BAL_P   = '{4'b0100, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam drive_t DRV_BAL_N   = '{4'b1000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1};
    // Second discharge path uses the TOP3/BOT4 leg but reports it as o_plus.
    localparam drive_t DRV_DISCH_B = '{4'b0100, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic drive_t drive_for(input cmd_t c);
        case (c)
            CMD_PLUS:  return DRV_PLUS;
            CMD_MINUS: return DRV_MINUS;
            CMD_BAL_P: return DRV_BAL_P;
            CMD_BAL_N: return DRV_BAL_N;
            default:   return DRV_OFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_deadtime.sv
// ----------------------------------------------------------------------------
// hbridge_deadtime: holds a new switch pattern off for DEADTIME_CYC cycles. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hbridge_deadtime
    import hbridge_pkg::*;
#(
    parameter int DEADTIME_CYC = 50
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_valid,
    input  drive_t req,
    input  logic   cancel,
    output drive_t drv,
    output logic   busy
);

    localparam int CW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (DEADTIME_CYC > 0) ? CW'(DEADTIME_CYC - 1) : '0;

    drive_t        drv_q;
    drive_t        pend;
    logic          busy_q;
    logic [CW-1:0] cnt;
    logic          need_gap;

    assign need_gap = (DEADTIME_CYC != 0) && ({drv_q.top, drv_q.bot} != 8'h00) && (req != drv_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_q  <= DRV_OFF;
            pend   <= DRV_OFF;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else if (cancel) begin
            drv_q  <= DRV_OFF;
            pend   <= DRV_OFF;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else if (busy_q) begin
            // A newer request only replaces what is pending; the gap keeps counting.
            if (req_valid) begin
                pend <= req;
            end
            if (cnt == '0) begin
                drv_q  <= req_valid ? req : pend;
                busy_q <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (req_valid) begin
            if (need_gap) begin
                drv_q  <= DRV_OFF;
                pend   <= req;
                busy_q <= 1'b1;
                cnt    <= CNT_LOAD;
            end else begin
                drv_q <= req;
            end
        end
    end

    assign drv  = drv_q;
    assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/hbridge_seq.sv
// ----------------------------------------------------------------------------
// hbridge_seq: frame decoder, precharge/start sequencer and fault latch. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hbridge_seq
    import hbridge_pkg::*;
#(
    parameter int FREQ          = 50000000,
    parameter int T_PRECHARGE_S = 15,
    parameter int T_SETTLE_S    = 1,
    parameter int DEADTIME_CYC  = 50,
    parameter int NUM_ERR       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_clk,
    input  logic [2:0]         bus,
    input  logic [NUM_ERR-1:0] err,
    output logic [3:0]         top,
    output logic [3:0]         bot,
    output logic               o_plus,
    output logic               o_minus,
    output logic               o_pause_p,
    output logic               o_pause_n,
    output logic               o_st,
    output logic               o_ch,
    output logic               o_fan,
    output logic               o_break,
    output logic [NUM_ERR-1:0] err_latched,
    output logic               deadtime,
    output logic               idle
);

    localparam int T_MAX_S = (T_PRECHARGE_S > T_SETTLE_S) ? T_PRECHARGE_S : T_SETTLE_S;
    localparam int TMAX    = FREQ * T_MAX_S;
    localparam int TW      = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] PRE_LOAD = TW'(FREQ * T_PRECHARGE_S);
    localparam logic [TW-1:0] SET_LOAD = TW'(FREQ * T_SETTLE_S);

    typedef struct packed {
        dec_state_t         dec;
        seq_state_t         seq;
        logic [TW-1:0]      tmr;
        logic               st;
        logic               ch;
        logic               fan;
        logic               brk;
        logic [NUM_ERR-1:0] el;
        logic               bclk_q;
        logic               idle;
    } rec_t;

    rec_t          r;
    rec_t          nx;
    cmd_t          code;
    logic          bus_fall;
    logic          seq_busy;
    logic          run_ok;
    logic [TW-1:0] tmr_next;
    logic          req_valid;
    drive_t        req;
    logic          cancel;
    drive_t        drv;
    logic          dt_busy;

    always_comb begin
        nx        = r;
        req_valid = 1'b0;
        req       = DRV_OFF;
        cancel    = 1'b0;
        code      = cmd_t'(bus);
        bus_fall  = r.bclk_q & ~bus_clk;
        seq_busy  = (r.seq != S_IDLE);
        run_ok    = r.st & ~r.ch & ~seq_busy;
        tmr_next  = (r.tmr == '0) ? '0 : r.tmr - 1'b1;

        nx.bclk_q = bus_clk;
        nx.el     = r.el | err;
        nx.tmr    = tmr_next;

        // Stage ends in the same cycle the countdown lands on zero.
        case (r.seq)
            S_PRECHG: begin
                if (tmr_next == '0) begin
                    nx.st  = 1'b1;
                    nx.tmr = SET_LOAD;
                    nx.seq = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_next == '0) begin
                    nx.ch  = 1'b0;
                    nx.seq = S_IDLE;
                end
            end
            default: ;
        endcase

        if (|err) begin
            cancel = 1'b1;
            nx.dec = ERROR;
            nx.seq = S_IDLE;
            nx.tmr = '0;
            nx.st  = 1'b0;
            nx.ch  = 1'b0;
            nx.fan = 1'b1;
            nx.brk = 1'b1;
        end else if (bus_fall) begin
            if (r.dec == ERROR) begin
                if (code == CMD_SHUTDOWN) begin
                    nx.el  = '0;
                    nx.brk = 1'b0;
                    nx.fan = 1'b0;
                    nx.dec = IDLE;
                end
            end else if (code == CMD_SHUTDOWN) begin
                cancel = 1'b1;
                nx.seq = S_IDLE;
                nx.tmr = '0;
                nx.st  = 1'b0;
                nx.ch  = 1'b0;
                nx.fan = 1'b0;
                nx.dec = IDLE;
            end else begin
                nx.dec = IDLE;
                case (r.dec)
                    IDLE: begin
                        case (code)
                            CMD_PAUSE: if (!seq_busy) nx.dec = PAUSE;
                            CMD_START: if (!seq_busy) nx.dec = START;
                            CMD_DISCH: if (!seq_busy) nx.dec = DIS0;
                            default: begin
                                if (run_ok) begin
                                    req_valid = 1'b1;
                                    req       = drive_for(code);
                                end
                            end
                        endcase
                    end
                    PAUSE: if (code == CMD_PAUSE) cancel = 1'b1;
                    START: begin
                        if (code == CMD_PAUSE) begin
                            cancel = 1'b1;
                            nx.fan = 1'b1;
                            nx.ch  = 1'b1;
                            nx.st  = 1'b0;
                            nx.tmr = PRE_LOAD;
                            nx.seq = S_PRECHG;
                        end
                    end
                    DIS0: if (code == CMD_PAUSE) nx.dec = DIS1;
                    DIS1: if (code == CMD_DISCH) nx.dec = DIS2;
                    DIS2: if (code == CMD_PAUSE) nx.dec = DIS3;
                    DIS3: begin
                        if (!r.st && !r.ch && (code == CMD_PLUS || code == CMD_BAL_P)) begin
                            req_valid = 1'b1;
                            req       = (code == CMD_PLUS) ? DRV_PLUS : DRV_DISCH_B;
                        end
                    end
                    default: ;
                endcase
            end
        end

        nx.idle = (nx.dec == IDLE) && (nx.seq == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else begin
            r <= nx;
        end
    end

    hbridge_deadtime #(
        .DEADTIME_CYC(DEADTIME_CYC)
    ) u_deadtime (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req      (req),
        .cancel   (cancel),
        .drv      (drv),
        .busy     (dt_busy)
    );

    assign top         = drv.top;
    assign bot         = drv.bot;
    assign o_plus      = drv.plus;
    assign o_minus     = drv.minus;
    assign o_pause_p   = drv.pause_p;
    assign o_pause_n   = drv.pause_n;
    assign o_st        = r.st;
    assign o_ch        = r.ch;
    assign o_fan       = r.fan;
    assign o_break     = r.brk;
    assign err_latched = r.el;
    assign deadtime    = dt_busy;
    assign idle        = r.idle;

endmodule

`default_nettype wire

// File: tb/tb_hbridge_seq.sv
// ----------------------------------------------------------------------------
// tb_hbridge_seq: directed scoreboard bench for hbridge_seq. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hbridge_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_clk;
    logic [2:0] bus;
    logic [7:0] err;
    logic [3:0] top;
    logic [3:0] bot;
    logic       o_plus, o_minus, o_pause_p, o_pause_n;
    logic       o_st, o_ch, o_fan, o_break;
    logic [7:0] err_latched;
    logic       deadtime;
    logic       idle;

    hbridge_seq #(
        .FREQ         (100),
        .T_PRECHARGE_S(2),
        .T_SETTLE_S   (1),
        .DEADTIME_CYC (4),
        .NUM_ERR      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_clk    (bus_clk),
        .bus        (bus),
        .err        (err),
        .top        (top),
        .bot        (bot),
        .o_plus     (o_plus),
        .o_minus    (o_minus),
        .o_pause_p  (o_pause_p),
        .o_pause_n  (o_pause_n),
        .o_st       (o_st),
        .o_ch       (o_ch),
        .o_fan      (o_fan),
        .o_break    (o_break),
        .err_latched(err_latched),
        .deadtime   (deadtime),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern layout: {top, bot, plus, minus, pause_p, pause_n}
    localparam logic [11:0] P_OFF   = 12'h000;
    localparam logic [11:0] P_PLUS  = {4'b0001, 4'b0010, 4'b1000};
    localparam logic [11:0] P_MINUS = {4'b0010, 4'b0001, 4'b0100};
    localparam logic [11:0] P_DIS3  = {4'b0100, 4'b1000, 4'b1000};

    typedef struct {
        string       tag;
        logic [25:0] val;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;
    int   t0;

    logic [25:0] snap;
    assign snap = {top, bot, o_plus, o_minus, o_pause_p, o_pause_n,
                   o_st, o_ch, o_fan, o_break, err_latched, deadtime, idle};

    function automatic logic [25:0] mk(input logic [11:0] d, input logic st, input logic ch,
                                       input logic fan, input logic brk, input logic [7:0] el,
                                       input logic dt, input logic idl);
        return {d, st, ch, fan, brk, el, dt, idl};
    endfunction

    task automatic push(input string t, input logic [25:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got %h want <queued entry>", snap);
        end else begin
            e = sbq.pop_front();
            assert (snap === e.val) passed++;
            else begin
                fails++;
                $error("FAIL %s: got %h want %h", e.tag, snap, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the clock edge that consumed the frame.
    task automatic send(input logic [2:0] code);
        @(negedge clk);
        bus     = code;
        bus_clk = 1'b1;
        @(negedge clk);
        bus_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        bus     = 3'd0;
        bus_clk = 1'b0;
        err     = 8'h00;
        tick(3);
        push("reset", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 0));
        check_pop();
        rst = 1'b0;
        tick(1);
        push("idle_after_reset", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        check_pop();

        push("drive_before_start", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        send(3'd1);
        check_pop();

        // Start sequence timing
        push("start_ch_fan", mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 0));
        send(3'd5);
        send(3'd0);
        check_pop();
        t0 = cyc;
        push("prechg_code1", mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 0));
        send(3'd1);
        check_pop();
        wait_cyc(t0 + 199);
        push("st_before_rise", mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 0));
        check_pop();
        wait_cyc(t0 + 200);
        push("st_rise", mk(P_OFF, 1, 1, 1, 0, 8'h00, 0, 0));
        check_pop();
        push("settle_5_0_ignored", mk(P_OFF, 1, 1, 1, 0, 8'h00, 0, 0));
        send(3'd5);
        send(3'd0);
        check_pop();
        wait_cyc(t0 + 299);
        push("ch_before_fall", mk(P_OFF, 1, 1, 1, 0, 8'h00, 0, 0));
        check_pop();
        wait_cyc(t0 + 300);
        push("ch_fall_idle", mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 1));
        check_pop();

        // Drive with dead time
        push("drive_plus", mk(P_PLUS, 1, 0, 1, 0, 8'h00, 0, 1));
        send(3'd1);
        check_pop();
        push("dt_off_1", mk(P_OFF, 1, 0, 1, 0, 8'h00, 1, 1));
        send(3'd2);
        check_pop();
        for (int i = 2; i <= 4; i++) begin
            tick(1);
            push($sformatf("dt_off_%0d", i), mk(P_OFF, 1, 0, 1, 0, 8'h00, 1, 1));
            check_pop();
        end
        tick(1);
        push("drive_minus", mk(P_MINUS, 1, 0, 1, 0, 8'h00, 0, 1));
        check_pop();

        // Fault latch and clear
        push("fault_pulse", mk(P_OFF, 0, 0, 1, 1, 8'h08, 0, 0));
        err = 8'h08;
        tick(1);
        err = 8'h00;
        check_pop();
        push("clear_blocked", mk(P_OFF, 0, 0, 1, 1, 8'h08, 0, 0));
        err = 8'h08;
        send(3'd6);
        check_pop();
        err = 8'h00;
        tick(1);
        push("clear_ok", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        send(3'd6);
        check_pop();

        // Discharge chain
        push("discharge_3", mk(P_DIS3, 0, 0, 0, 0, 8'h00, 0, 1));
        send(3'd7);
        send(3'd0);
        send(3'd7);
        send(3'd0);
        send(3'd3);
        check_pop();
        push("dis_chain_mid", mk(P_DIS3, 0, 0, 0, 0, 8'h00, 0, 0));
        send(3'd7);
        check_pop();
        push("dis_chain_abort", mk(P_DIS3, 0, 0, 0, 0, 8'h00, 0, 1));
        send(3'd0);
        send(3'd5);
        check_pop();

        // Shutdown during dead time
        push("start2", mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 0));
        send(3'd5);
        send(3'd0);
        check_pop();
        t0 = cyc;
        wait_cyc(t0 + 300);
        push("run2", mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 1));
        check_pop();
        push("plus2", mk(P_PLUS, 1, 0, 1, 0, 8'h00, 0, 1));
        send(3'd1);
        check_pop();
        push("dt2_start", mk(P_OFF, 1, 0, 1, 0, 8'h00, 1, 1));
        send(3'd2);
        check_pop();
        push("shutdown_mid_dt", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        send(3'd6);
        check_pop();
        tick(3);
        push("shutdown_hold", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        check_pop();

        // Reset mid-precharge
        push("prechg3", mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 0));
        send(3'd5);
        send(3'd0);
        check_pop();
        tick(50);
        push("rst_mid_prechg", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 0));
        rst = 1'b1;
        tick(1);
        check_pop();
        rst = 1'b0;
        tick(1);
        push("idle_after_rst2", mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
        check_pop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
